// File: rtl/cordic_iter_gen.sv
// cordic_iter_gen: iterative CORDIC engine, one micro-rotation per clock, rotation and vectoring modes
module cordic_iter_gen #(
  parameter int WIDTH  = 10,
  parameter int N_ITER = WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    mode_i,
  input  logic signed [WIDTH-1:0] X_i,
  input  logic signed [WIDTH-1:0] Y_i,
  input  logic signed [WIDTH-1:0] Z_i,
  output logic signed [WIDTH-1:0] X_o,
  output logic signed [WIDTH-1:0] Y_o,
  output logic signed [WIDTH-1:0] Z_o,
  output logic                    valid_o,
  input  logic                    ready_i
);
  localparam int IW = $clog2(N_ITER + 1);
  localparam logic signed [WIDTH-1:0] PI_HALF = WIDTH'(2 ** (WIDTH - 2));
  // atan(2^-i) scaled so that 2^31 is pi; narrowed to WIDTH bits with round-half-up
  localparam logic [31:0] T_TAB [32] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };
  typedef enum logic [1:0] {IDLE, ROC, ITER, DONE} state_t;
  state_t state, state_nx;
  logic signed [WIDTH-1:0] x, y, z;
  logic signed [WIDTH-1:0] x_roc, y_roc, z_roc;
  logic signed [WIDTH-1:0] x_it, y_it, z_it;
  logic signed [WIDTH-1:0] xs, ys, a;
  logic mode, accept, d_pos, up, dn;
  logic [IW-1:0] i;
  // keep one extra fraction bit through the shift, then add one and drop it
  function automatic logic signed [WIDTH-1:0] atan_of(input logic [IW-1:0] k);
    return WIDTH'((((({2'b00, T_TAB[5'(k)]}) << 1) >> (32 - WIDTH)) + 34'd1) >> 1);
  endfunction
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  // next state: a fresh sample may be taken straight out of DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? ROC : IDLE;
      ROC:     state_nx = ITER;
      ITER:    state_nx = (i == IW'(N_ITER - 1)) ? DONE : ITER;
      DONE:    state_nx = accept ? ROC : (ready_i ? IDLE : DONE);
      default: state_nx = IDLE;
    endcase
  end
  // handshake outputs; ready is suppressed for the whole time reset is held
  always_comb begin
    ready_o = !rst_i && (state == IDLE || (state == DONE && ready_i));
    valid_o = state == DONE;
    accept  = valid_i && ready_o;
  end
  // coarse quarter turn so the fine stage only has to cover +/- pi/2
  always_comb begin
    up    = mode ? (x[WIDTH-1] && y[WIDTH-1]) : (z > PI_HALF);
    dn    = mode ? (x[WIDTH-1] && !y[WIDTH-1]) : (z < -PI_HALF);
    x_roc = up ? -y : (dn ? y : x);
    y_roc = up ? x : (dn ? -x : y);
    z_roc = up ? z - PI_HALF : (dn ? z + PI_HALF : z);
  end
  // one shift-and-add micro-rotation, direction chosen to drive Z (rotation) or Y (vectoring) to zero
  always_comb begin
    d_pos = mode ? y[WIDTH-1] : !z[WIDTH-1];
    xs    = x >>> i;
    ys    = y >>> i;
    a     = atan_of(i);
    x_it  = d_pos ? x - ys : x + ys;
    y_it  = d_pos ? y + xs : y - xs;
    z_it  = d_pos ? z - a : z + a;
  end
  // working registers and iteration counter
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      mode <= 1'b0;
      i    <= '0;
    end else if (accept) begin
      x    <= X_i;
      y    <= Y_i;
      z    <= Z_i;
      mode <= mode_i;
    end else if (state == ROC) begin
      x <= x_roc;
      y <= y_roc;
      z <= z_roc;
      i <= '0;
    end else if (state == ITER) begin
      x <= x_it;
      y <= y_it;
      z <= z_it;
      i <= i + IW'(1);
    end
  assign X_o = x;
  assign Y_o = y;
  assign Z_o = z;
endmodule

// File: tb/tb_cordic_iter_gen.sv
// tb_cordic_iter_gen: scoreboard bench for cordic_iter_gen against an integer CORDIC reference
module tb_cordic_iter_gen;
  localparam int W = 10;
  localparam int N = 10;
  logic clk_i = 0, rst_i = 1, valid_i = 0, mode_i = 0;
  logic rdy_dir = 1, bp_rnd = 1, rand_bp = 0;
  logic ready_i, ready_o, valid_o;
  logic signed [W-1:0] X_i = 0, Y_i = 0, Z_i = 0, X_o, Y_o, Z_o;
  int errors = 0, checks = 0, cyc = 0;
  int atan_tab [N];
  logic [3*W-1:0] exp_q [$];
  int pop_cyc [$];
  assign ready_i = rand_bp ? bp_rnd : rdy_dir;
  cordic_iter_gen #(.WIDTH(W), .N_ITER(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .mode_i(mode_i),
    .X_i(X_i), .Y_i(Y_i), .Z_i(Z_i), .X_o(X_o), .Y_o(Y_o), .Z_o(Z_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) begin
    cyc++;
    #1 bp_rnd = 1'($urandom_range(0, 1));
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic near(input string name, input int act, input int exp, input int tol);
    logic signed [W-1:0] d;
    d = W'(act - exp);
    checks++;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask
  function automatic int wrap(input int v);
    logic signed [W-1:0] t;
    t = W'(v);
    return int'(t);
  endfunction
  // reference: integer CORDIC with explicit +/-1 direction and wrap to W bits
  function automatic logic [3*W-1:0] model(input logic m, input logic signed [W-1:0] xi, yi, zi);
    int x, y, z, t, d, ph;
    ph = 2 ** (W - 2);
    x = xi; y = yi; z = zi;
    if ((!m && z > ph) || (m && x < 0 && y < 0)) begin
      t = x; x = wrap(-y); y = t; z = wrap(z - ph);
    end else if ((!m && z < -ph) || (m && x < 0)) begin
      t = x; x = y; y = wrap(-t); z = wrap(z + ph);
    end
    for (int k = 0; k < N; k++) begin
      d = (m ? (y < 0) : (z >= 0)) ? 1 : -1;
      t = x;
      x = wrap(x - d * (y >>> k));
      y = wrap(y + d * (t >>> k));
      z = wrap(z - d * atan_tab[k]);
    end
    return {W'(x), W'(y), W'(z)};
  endfunction
  // scoreboard push on every accepted sample
  always @(negedge clk_i)
    if (!rst_i && valid_i && ready_o) exp_q.push_back(model(mode_i, X_i, Y_i, Z_i));
  // monitor: pop on output handshake, check hold under backpressure
  logic [3*W-1:0] prev_out;
  logic held = 0;
  always @(negedge clk_i) begin : mon
    logic signed [W-1:0] ex, ey, ez;
    if (rst_i) held = 0;
    else begin
      if (held) begin
        chk("valid_held", int'(valid_o), 1);
        chk("out_stable", int'({X_o, Y_o, Z_o}), int'(prev_out));
      end
      if (valid_o && ready_i) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          {ex, ey, ez} = exp_q.pop_front();
          chk("x_o", int'(X_o), int'(ex));
          chk("y_o", int'(Y_o), int'(ey));
          chk("z_o", int'(Z_o), int'(ez));
        end
      end
      held = valid_o && !ready_i;
      prev_out = {X_o, Y_o, Z_o};
    end
  end
  task automatic send(input logic m, input int x, input int y, input int z);
    int n;
    n = 0;
    mode_i = m; X_i = W'(x); Y_i = W'(y); Z_i = W'(z); valid_i = 1;
    @(negedge clk_i);
    while (!ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) chk("accept_timeout", 0, 1);
    @(posedge clk_i);
    #1 valid_i = 0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 300) begin
      @(posedge clk_i);
      #1 n++;
    end
  endtask
  task automatic directed(input string name, input logic m, input int x, input int y, input int z,
                          input int ex, input int ey, input int ez);
    int n;
    send(m, x, y, z);
    wait_valid(n);
    chk({name, "_latency"}, n, N + 1);
    near({name, "_x"}, int'(X_o), ex, 4);
    near({name, "_y"}, int'(Y_o), ey, 4);
    near({name, "_z"}, int'(Z_o), ez, 2);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, vcnt;
    logic [3*W-1:0] snap;
    for (int k = 0; k < N; k++)
      atan_tab[k] = int'($floor($atan(1.0 / (2.0 ** k)) / 3.14159265358979 * (2.0 ** (W - 1)) + 0.5));
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", int'(ready_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_regs", int'({X_o, Y_o, Z_o}), 0);
    rst_i = 0;
    #1;
    chk("idle_ready", int'(ready_o), 1);
    chk("idle_valid", int'(valid_o), 0);
    directed("rot0", 0, 256, 0, 0, 422, 0, 0);
    directed("rot3q", 0, 128, 0, 384, -149, 149, 0);
    directed("vec45", 1, 128, 128, 0, 298, 0, 128);
    directed("vecneg", 1, -128, 0, 0, 211, 0, 512);
    repeat (2) begin @(posedge clk_i); #1; end
    rdy_dir = 0;
    send(0, 200, -100, 50);
    wait_valid(n);
    chk("bp_first_latency", n, N + 1);
    snap = {X_o, Y_o, Z_o};
    repeat (5) begin
      valid_i = 1; mode_i = 1'($urandom_range(0, 1));
      X_i = W'($urandom); Y_i = W'($urandom); Z_i = W'($urandom);
      @(negedge clk_i);
      chk("bp_ready", int'(ready_o), 0);
      chk("bp_valid", int'(valid_o), 1);
      chk("bp_hold", int'({X_o, Y_o, Z_o}), int'(snap));
      @(posedge clk_i);
      #1 valid_i = 0;
      @(posedge clk_i);
      #1;
    end
    rdy_dir = 1;
    send(1, 100, -50, 0);
    wait_valid(n);
    chk("bp_next_latency", n, N + 1);
    repeat (2) begin @(posedge clk_i); #1; end
    pop_cyc.delete();
    send(0, 256, 0, 0);
    send(0, 128, 0, 384);
    send(1, 128, 128, 0);
    send(1, -128, 0, 0);
    wait_valid(n);
    repeat (2) begin @(posedge clk_i); #1; end
    chk("b2b_count", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4)
      for (int k = 1; k < 4; k++) chk("b2b_spacing", pop_cyc[k] - pop_cyc[k-1], N + 2);
    send(0, 150, 60, 200);
    repeat (6) begin @(posedge clk_i); #1; end
    rst_i = 1;
    exp_q.delete();
    #1;
    chk("midrst_ready", int'(ready_o), 0);
    chk("midrst_valid", int'(valid_o), 0);
    @(posedge clk_i);
    #1;
    chk("midrst_valid_hold", int'(valid_o), 0);
    rst_i = 0;
    #1;
    chk("midrst_release_ready", int'(ready_o), 1);
    vcnt = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (valid_o) vcnt++;
    end
    chk("aborted_valid", vcnt, 0);
    rand_bp = 1;
    repeat (60) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      send(1'($urandom_range(0, 1)), int'($urandom), int'($urandom), int'($urandom));
    end
    rand_bp = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk_i);
      #1 n++;
    end
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
